// File: rtl/raster_scan_gen.sv
// Raster scan generator: walks N_COLS x N_ROWS positions, one per accepted beat,
// with single/continuous modes, graceful stop at frame end, abort and frame counter.
module raster_scan_gen #(
  parameter int N_COLS = 640,
  parameter int N_ROWS = 480,
  parameter int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1,
  parameter int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  parameter int ADDR_W = (N_COLS * N_ROWS > 1) ? $clog2(N_COLS * N_ROWS) : 1,
  parameter int FRM_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic              i_stop,
  input  logic              i_abort,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [COL_W-1:0]  o_col,
  output logic [ROW_W-1:0]  o_row,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_sol,
  output logic              o_eol,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [FRM_W-1:0]  o_frame_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

  state_t              state_reg, state_next;
  logic                mode_reg, mode_next;
  logic                stop_pend_reg, stop_pend_next;
  logic [COL_W-1:0]    col_reg, col_next;
  logic [ROW_W-1:0]    row_reg, row_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                frame_done_reg, frame_done_next;
  logic [FRM_W-1:0]    frame_cnt_reg, frame_cnt_next;

  logic last_col;
  logic last_row;

  assign last_col = (col_reg == COL_LAST);
  assign last_row = (row_reg == ROW_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg      <= IDLE;
      mode_reg       <= 1'b0;
      stop_pend_reg  <= 1'b0;
      col_reg        <= '0;
      row_reg        <= '0;
      addr_reg       <= '0;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      mode_reg       <= mode_next;
      stop_pend_reg  <= stop_pend_next;
      col_reg        <= col_next;
      row_reg        <= row_next;
      addr_reg       <= addr_next;
      frame_done_reg <= frame_done_next;
      frame_cnt_reg  <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    mode_next       = mode_reg;
    stop_pend_next  = stop_pend_reg;
    col_next        = col_reg;
    row_next        = row_reg;
    addr_next       = addr_reg;
    frame_done_next = 1'b0;
    frame_cnt_next  = frame_cnt_reg;

    if (i_abort) begin
      // Abort wins over everything but keeps the completed-frame count.
      state_next     = IDLE;
      stop_pend_next = 1'b0;
      col_next       = '0;
      row_next       = '0;
      addr_next      = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            state_next     = RUN;
            mode_next      = i_mode;
            stop_pend_next = 1'b0;
            frame_cnt_next = '0;
            col_next       = '0;
            row_next       = '0;
            addr_next      = '0;
          end
        end
        RUN: begin
          if (mode_reg && i_stop) begin
            stop_pend_next = 1'b1;
          end
          if (i_ready) begin
            if (!last_col) begin
              col_next  = col_reg + COL_W'(1);
              addr_next = addr_reg + ADDR_W'(1);
            end else if (!last_row) begin
              col_next  = '0;
              row_next  = row_reg + ROW_W'(1);
              addr_next = addr_reg + ADDR_W'(1);
            end else begin
              // Frame end: wrap without a bubble unless the run is over.
              col_next        = '0;
              row_next        = '0;
              addr_next       = '0;
              frame_done_next = 1'b1;
              frame_cnt_next  = frame_cnt_reg + FRM_W'(1);
              if (!mode_reg || stop_pend_reg || i_stop) begin
                state_next     = IDLE;
                stop_pend_next = 1'b0;
              end
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign o_valid      = (state_reg == RUN);
  assign o_busy       = (state_reg == RUN);
  assign o_col        = col_reg;
  assign o_row        = row_reg;
  assign o_addr       = addr_reg;
  assign o_frame_done = frame_done_reg;
  assign o_frame_cnt  = frame_cnt_reg;
  assign o_sol        = o_valid && (col_reg == '0);
  assign o_eol        = o_valid && last_col;
  assign o_sof        = o_sol && (row_reg == '0);
  assign o_eof        = o_eol && last_row;

endmodule
